mux_16_to_1: RTL and testbench
==============================

Name: mux_16_to_1

Overview:
Registered 16:1 data multiplexer. It selects one of sixteen WIDTH-bit inputs using a 4-bit select. It registers the result behind a simple valid qualifier. It serves as a generic datapath selector between upstream sources and a single consumer, one clock domain.

Parameters:
WIDTH, 4, bit width of each data input and of the output.

Ports:
clk  input  1  single system clock, rising-edge active
rst  input  1  synchronous, active-high reset
in_valid  input  1  qualifies sel/inputs this cycle; capture occurs only when high
sel  input  4  select index, 0 selects in0 … 15 selects in15
in0 … in15  input  WIDTH each  sixteen data inputs (16 separate ports)
out  output  WIDTH  registered selected data
out_valid  output  1  high for the cycle after a capture

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, out <= 0 and out_valid <= 0. Reset has priority over in_valid. Reset mid-stream discards the pending capture.
- Capture: on a rising clk edge with rst=0 and in_valid=1, out <= in[sel] and out_valid <= 1.
- Hold: with rst=0 and in_valid=0, out holds its last value and out_valid <= 0.
- Latency is exactly 1 cycle from sel/in change (with in_valid=1) to out. There is no combinational path from inputs to out.
- All 16 select codes are legal. No out-of-range case exists.
- Select wrap: sel incrementing 15→0 simply selects in0. No special handling.
- Inputs change freely between captures. Only values present at the capturing edge matter.
- Width rule: out is exactly the selected input, with no extension, truncation or arithmetic.
- X on sel while in_valid=0 must not affect out.

Optional Feature:
Macro MUX_16_TO_1_SEL_ONEHOT_EN.
- Defined: adds output port sel_onehot (16 bits). It is registered alongside out: on capture it is 1<<sel. On reset it is 0. When in_valid=0 it holds.
- Undefined: port and its register are absent. All other behaviour is identical.

Decomposition:
- Package mux_16_to_1_pkg holds:
  - NUM_INPUTS=16
  - SEL_W=4
  - DEFAULT_WIDTH=4
- Natural sub-module: mux_4_to_1 (combinational, WIDTH-parameterised). Five instances form a two-level tree: four leaf instances on sel[1:0] and one root on sel[3:2]. The output register lives in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → out=0, out_valid=0; after release with in_valid=0 → both stay 0.
- Full sweep, WIDTH=4. Inputs:
  - in0=1010, in1=1110, in2=0010, in3=0110
  - in4=1011, in5=1100, in6=0111, in7=1110
  - in8=0101, in9=0000, in10=1001, in11=1111
  - in12=1011, in13=1011, in14=1110, in15=0111
  - Stimulus: in_valid=1, sel stepping 0..15 one per cycle → out equals the corresponding input one cycle later, out_valid=1 each cycle.
- Wrap: sel 15 then 0 on consecutive cycles → out 0111 then 1010.
- Hold: capture sel=11 (1111), then in_valid=0 while sel and inputs change → out stays 1111, out_valid=0.
- Reset priority: in_valid=1, sel=4, rst=1 same edge → out=0, out_valid=0; next edge with rst=0 → out=1011.
- With MUX_16_TO_1_SEL_ONEHOT_EN defined: capture sel=9 → sel_onehot=0x0200, out=0000.

Source files
------------

// File: rtl/mux_16_to_1_pkg.sv
// Shared sizing constants for the registered 16:1 selector.
package mux_16_to_1_pkg;
  localparam int NUM_INPUTS    = 16;
  localparam int SEL_W         = 4;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/mux_4_to_1.sv
// Combinational 4:1 selector, the building block of the two-level select tree.
module mux_4_to_1 #(
  parameter int WIDTH = 4
) (
  input  logic [3:0][WIDTH-1:0] d,
  input  logic [1:0]            sel,
  output logic [WIDTH-1:0]      y
);
  assign y = d[sel];
endmodule

// File: rtl/mux_16_to_1.sv
// Registered 16:1 selector with a valid qualifier; the output register lives here.
// Optional MUX_16_TO_1_SEL_ONEHOT_EN adds a registered one-hot copy of the captured select.
module mux_16_to_1
  import mux_16_to_1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
  ,
  output logic [NUM_INPUTS-1:0] sel_onehot
`endif
);
  localparam int NUM_LEAF = NUM_INPUTS / 4;

  logic [NUM_INPUTS-1:0][WIDTH-1:0] din;
  logic [NUM_LEAF-1:0][WIDTH-1:0]   leaf_y;
  logic [WIDTH-1:0]                 mux_y;

  assign din = {in15, in14, in13, in12, in11, in10, in9, in8,
                in7,  in6,  in5,  in4,  in3,  in2,  in1, in0};

  // Leaves resolve sel[1:0] within each group of four; root picks the group.
  for (genvar g = 0; g < NUM_LEAF; g++) begin : g_leaf
    mux_4_to_1 #(.WIDTH(WIDTH)) u_leaf (
      .d   (din[4*g +: 4]),
      .sel (sel[1:0]),
      .y   (leaf_y[g])
    );
  end

  mux_4_to_1 #(.WIDTH(WIDTH)) u_root (
    .d   (leaf_y),
    .sel (sel[3:2]),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
      sel_onehot <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      // Data holds when not qualified, so a garbage sel cannot disturb it.
      if (in_valid) begin
        out <= mux_y;
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
        sel_onehot <= {{(NUM_INPUTS-1){1'b0}}, 1'b1} << sel;
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_mux_16_to_1.sv
// Self-checking bench: directed vectors with literal expectations plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_mux_16_to_1;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   sel;
  logic [W-1:0] inp [16];
  logic [W-1:0] out;
  logic         out_valid;
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
  logic [15:0]  sel_onehot;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_16_to_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel),
    .in0(inp[0]),   .in1(inp[1]),   .in2(inp[2]),   .in3(inp[3]),
    .in4(inp[4]),   .in5(inp[5]),   .in6(inp[6]),   .in7(inp[7]),
    .in8(inp[8]),   .in9(inp[9]),   .in10(inp[10]), .in11(inp[11]),
    .in12(inp[12]), .in13(inp[13]), .in14(inp[14]), .in15(inp[15]),
    .out(out), .out_valid(out_valid)
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
    , .sel_onehot(sel_onehot)
`endif
  );

  // Test-plan input set, indexed by select code.
  logic [W-1:0] tbl [16] = '{4'b1010, 4'b1110, 4'b0010, 4'b0110,
                             4'b1011, 4'b1100, 4'b0111, 4'b1110,
                             4'b0101, 4'b0000, 4'b1001, 4'b1111,
                             4'b1011, 4'b1011, 4'b1110, 4'b0111};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tbl();
    for (int i = 0; i < 16; i++) inp[i] = tbl[i];
  endtask

  // Reference model: the register is a pure function of what was present at each edge.
  bit           m_ok = 0;
  logic [W-1:0] m_out;
  logic         m_vld;
  logic [15:0]  m_oh;
  always @(posedge clk) begin
    if (rst) begin
      m_out = '0; m_vld = 1'b0; m_oh = '0; m_ok = 1;
    end else if (in_valid) begin
      m_out = inp[sel]; m_vld = 1'b1; m_oh = 16'(2 ** int'(sel));
    end else begin
      m_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_out", 16'(out), 16'(m_out));
      chk("model_valid", 16'(out_valid), 16'(m_vld));
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
      chk("model_onehot", sel_onehot, m_oh);
`endif
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 4'd7;
    for (int i = 0; i < 16; i++) inp[i] = 4'($urandom);
    tick(); tick();
    chk("reset_out", 16'(out), 16'h0);
    chk("reset_valid", 16'(out_valid), 16'h0);
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
    chk("reset_onehot", sel_onehot, 16'h0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("idle_out", 16'(out), 16'h0);
    chk("idle_valid", 16'(out_valid), 16'h0);

    load_tbl();
    in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      tick();
      chk($sformatf("sweep%0d", s), 16'(out), 16'(tbl[s]));
      chk($sformatf("sweep_valid%0d", s), 16'(out_valid), 16'h1);
    end

    sel = 4'd15; tick(); chk("wrap15", 16'(out), 16'h7);
    sel = 4'd0;  tick(); chk("wrap0", 16'(out), 16'hA);

    sel = 4'd11; tick(); chk("hold_cap", 16'(out), 16'hF);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = 4'($urandom);
      for (int i = 0; i < 16; i++) inp[i] = 4'($urandom);
      tick();
      chk("hold_out", 16'(out), 16'hF);
      chk("hold_valid", 16'(out_valid), 16'h0);
    end

    load_tbl();
    in_valid = 1'b1; sel = 4'd4; rst = 1'b1;
    tick();
    chk("rstpri_out", 16'(out), 16'h0);
    chk("rstpri_valid", 16'(out_valid), 16'h0);
    rst = 1'b0;
    tick();
    chk("rstpri_after", 16'(out), 16'hB);
    chk("rstpri_after_valid", 16'(out_valid), 16'h1);

    sel = 4'd9; tick();
    chk("sel9_out", 16'(out), 16'h0);
`ifdef MUX_16_TO_1_SEL_ONEHOT_EN
    chk("sel9_onehot", sel_onehot, 16'h0200);
    in_valid = 1'b0; sel = 4'd2; tick();
    chk("onehot_hold", sel_onehot, 16'h0200);
`endif

    // Random traffic, checked only by the model.
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'($urandom);
      sel = 4'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 16; i++) inp[i] = 4'($urandom);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
